frame_render_sequencer: RTL
===========================

FRAME_RENDER_SEQUENCER -- requirements
Module: frame_render_sequencer

Interface
REQ-001 Parameter XMAX, default 159: last column index of the sweep.
REQ-002 Parameter YMAX, default 119: last row index of the sweep.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 enable  input  1  when high, frameTick may start a frame.
REQ-006 frameTick  input  1  one-cycle frame-rate pulse.
REQ-007 logicStart  output  1  one-cycle pulse telling game logic to advance one step.
REQ-008 logicDone  input  1  game logic finished its step (pulse or level).
REQ-009 qx, qy  output  8 each  query coordinate presented to the pixel renderer.
REQ-010 pixColor  input  3  renderer colour for (qx,qy), combinational, same cycle.
REQ-011 x, y  output  8 each  registered plot coordinate to framebuffer port.
REQ-012 color  output  3  registered plot colour.
REQ-013 plotValid  output  1  x/y/color hold a pixel awaiting acceptance.
REQ-014 plotReady  input  1  framebuffer accepts a pixel when plotValid and plotReady are both high.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 frameDone  output  1  one-cycle pulse when the last pixel of a frame is accepted.
REQ-017 overrunCount  output  8  count of dropped frameTicks, saturating.

Function
REQ-018 FSM states: IDLE, UPDATE, WAIT_LOGIC, SWEEP, DRAIN, DONE.
REQ-019 IDLE: frameTick && enable -> UPDATE; frameTick && !enable ignored, not counted.
REQ-020 UPDATE lasts exactly one cycle with logicStart=1, then WAIT_LOGIC.
REQ-021 WAIT_LOGIC: stay until logicDone=1, then SWEEP with qx=0, qy=0; logicDone in any other state is ignored.
REQ-022 SWEEP: pipeline advances when (!plotValid || plotReady); on advance, x<=qx, y<=qy, color<=pixColor, plotValid<=1, and the query counter steps.
REQ-023 Query stepping: qx+1 while qx<XMAX; at qx=XMAX, qx<=0 and qy+1; advance that captures (XMAX,YMAX) moves to DRAIN and leaves qx/qy at 0.
REQ-024 Stall (plotValid && !plotReady): x, y, color, qx, qy and plotValid hold unchanged.
REQ-025 DRAIN: when plotReady accepts the final pixel, plotValid<=0 and next state DONE.
REQ-026 DONE: frameDone=1 for exactly one cycle, then IDLE.
REQ-027 plotValid is 0 in IDLE, UPDATE, WAIT_LOGIC, DONE, and on first SWEEP cycle.
REQ-028 Each frame produces exactly (XMAX+1)*(YMAX+1) accepted pixels, in raster order, no duplicates or gaps.
REQ-029 frameTick in any state other than IDLE: tick dropped, overrunCount+1, saturating at 255.
REQ-030 enable deasserted mid-frame does not abort; the frame completes normally.
REQ-031 Minimum frame latency, frameTick to frameDone with logicDone at first WAIT_LOGIC cycle and plotReady always 1: 2 + (XMAX+1)*(YMAX+1) + 2 cycles.
REQ-032 Counters are 8-bit unsigned; XMAX, YMAX <= 255.

Reset
REQ-033 resetn=0 at clock edge: state IDLE; x=y=qx=qy=0; color=0; plotValid=0; logicStart=0; frameDone=0; busy=0; overrunCount=0.
REQ-034 Reset mid-frame aborts immediately; no pixel accepted after reset edge; the first post-reset frameTick starts a full frame from (0,0).

Verification
REQ-035 Reset, enable=1, one frameTick, logicDone 3 cycles after logicStart, plotReady=1 -> 19200 accepted pixels (0,0)..(159,119) in raster order, colour = pixColor model, single frameDone, overrunCount=0.
REQ-036 Random plotReady (50%) during sweep -> x/y/color stable across every stall; pixel sequence identical to REQ-035.
REQ-037 frameTick pulsed 3 times during one SWEEP and once in DONE -> overrunCount=4; no extra frame started; tick 300 times total in busy states -> overrunCount saturates at 255.
REQ-038 enable=0, frameTick -> stays IDLE, busy=0, overrunCount unchanged; enable dropped during SWEEP -> frame completes.
REQ-039 resetn=0 at pixel (80,60) -> plotValid=0 next cycle, all outputs at reset values; next frameTick -> sweep restarts from (0,0).
REQ-040 XMAX=3, YMAX=1, plotReady=1 -> exactly 8 pixels, frameDone 12 cycles after frameTick with logicDone held high.

Source files
------------

// File: rtl/frame_render_sequencer.sv
// Frame sequencer: on a frame tick it kicks game logic, then sweeps every
// (qx,qy) in raster order and streams the renderer's colours out over a valid/ready plot port.
module frame_render_sequencer #(
  parameter int XMAX = 159,
  parameter int YMAX = 119
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       frameTick,
  output logic       logicStart,
  input  logic       logicDone,
  output logic [7:0] qx,
  output logic [7:0] qy,
  input  logic [2:0] pixColor,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic [2:0] color,
  output logic       plotValid,
  input  logic       plotReady,
  output logic       busy,
  output logic       frameDone,
  output logic [7:0] overrunCount,
  output logic [2:0] state_dbg
);

  // Plot handshake: x/y/color are meaningful while plotValid is high and
  // hold unchanged until the cycle where plotValid && plotReady transfers them.

  localparam logic [7:0] XLAST = 8'(XMAX);
  localparam logic [7:0] YLAST = 8'(YMAX);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_UPDATE     = 3'd1,
    S_WAIT_LOGIC = 3'd2,
    S_SWEEP      = 3'd3,
    S_DRAIN      = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] qx_q, qx_d;
  logic [7:0] qy_q, qy_d;
  logic [7:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic [2:0] color_q, color_d;
  logic       plot_valid_q, plot_valid_d;
  logic [7:0] overrun_q, overrun_d;

  logic advance;
  logic last_query;

  // The output register can take a new pixel when it is empty or being drained this cycle.
  assign advance    = (state_q == S_SWEEP) && (!plot_valid_q || plotReady);
  assign last_query = (qx_q == XLAST) && (qy_q == YLAST);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (frameTick && enable) state_d = S_UPDATE;
      S_UPDATE:     state_d = S_WAIT_LOGIC;
      S_WAIT_LOGIC: if (logicDone) state_d = S_SWEEP;
      S_SWEEP:      if (advance && last_query) state_d = S_DRAIN;
      S_DRAIN:      if (plotReady) state_d = S_DONE;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    logicStart = (state_q == S_UPDATE);
    frameDone  = (state_q == S_DONE);
    busy       = (state_q != S_IDLE);
    state_dbg  = state_q;
  end

  always_comb begin
    qx_d         = qx_q;
    qy_d         = qy_q;
    x_d          = x_q;
    y_d          = y_q;
    color_d      = color_q;
    plot_valid_d = plot_valid_q;
    overrun_d    = overrun_q;

    if ((state_q == S_WAIT_LOGIC) && logicDone) begin
      qx_d = 8'd0;
      qy_d = 8'd0;
    end

    if (advance) begin
      x_d          = qx_q;
      y_d          = qy_q;
      color_d      = pixColor;
      plot_valid_d = 1'b1;
      if (qx_q == XLAST) begin
        qx_d = 8'd0;
        qy_d = (qy_q == YLAST) ? 8'd0 : qy_q + 8'd1;
      end else begin
        qx_d = qx_q + 8'd1;
      end
    end

    if ((state_q == S_DRAIN) && plotReady) begin
      plot_valid_d = 1'b0;
    end

    // Ticks that arrive while a frame is in flight are dropped and counted.
    if (frameTick && (state_q != S_IDLE) && (overrun_q != 8'hFF)) begin
      overrun_d = overrun_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      qx_q         <= 8'd0;
      qy_q         <= 8'd0;
      x_q          <= 8'd0;
      y_q          <= 8'd0;
      color_q      <= 3'd0;
      plot_valid_q <= 1'b0;
      overrun_q    <= 8'd0;
    end else begin
      qx_q         <= qx_d;
      qy_q         <= qy_d;
      x_q          <= x_d;
      y_q          <= y_d;
      color_q      <= color_d;
      plot_valid_q <= plot_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign qx           = qx_q;
  assign qy           = qy_q;
  assign x            = x_q;
  assign y            = y_q;
  assign color        = color_q;
  assign plotValid    = plot_valid_q;
  assign overrunCount = overrun_q;

endmodule
